// File: rtl/axim_mem_slave.sv
// AXI4 memory-mapped responder backed by an internal word-addressed memory.
// Independent read and write FSMs, INCR bursts only, one burst per channel at a time.
// Optional: define AXIM_MEM_SLAVE_PROTO_CHK_EN to add the sticky proto_err wlast checker.
module axim_mem_slave #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_DEPTH        = 1024
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast
`ifdef AXIM_MEM_SLAVE_PROTO_CHK_EN
  ,
  output logic                            proto_err
`endif
);

  localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  w_state_e        w_state_q, w_state_d;
  logic [IdxW-1:0] w_start_q, w_start_d;
  logic [7:0]      w_len_q, w_len_d;
  logic [7:0]      w_beat_q, w_beat_d;
  logic            mem_we;
  logic [IdxW-1:0] w_idx;

  r_state_e        r_state_q, r_state_d;
  logic [IdxW-1:0] r_start_q, r_start_d;
  logic [7:0]      r_len_q, r_len_d;
  logic [7:0]      r_beat_q, r_beat_d;
  logic            rd_en;
  logic [IdxW-1:0] rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  // Keeps awready/arready low during reset and until the first clock after release.
  logic            ready_en_q;

  // Address bits outside the word index are intentionally ignored (aliasing).
  logic            unused_bits;
  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wlast};

  // Ready-enable flag: set on the first clock out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ready_en_q <= 1'b0;
    else       ready_en_q <= 1'b1;
  end

  // Write channel state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= WIdle;
      w_start_q <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_start_q <= w_start_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
    end
  end

  // Write FSM next state and handshake outputs; burst length comes from awlen only.
  always_comb begin
    w_state_d     = w_state_q;
    w_start_d     = w_start_q;
    w_len_d       = w_len_q;
    w_beat_d      = w_beat_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    mem_we        = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        s_axi_awready = ready_en_q;
        if (s_axi_awvalid && ready_en_q) begin
          w_start_d = s_axi_awaddr[OffW +: IdxW];
          w_len_d   = s_axi_awlen;
          w_beat_d  = '0;
          w_state_d = WData;
        end
      end
      WData: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_we   = 1'b1;
          w_beat_d = w_beat_q + 8'd1;
          if (w_beat_q == w_len_q) w_state_d = WResp;
        end
      end
      WResp: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Index arithmetic truncates to IdxW bits, so bursts wrap past the top of memory.
  assign w_idx = w_start_q + IdxW'(w_beat_q);

  // Byte-enabled memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read channel state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= RIdle;
      r_start_q <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_start_q <= r_start_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
    end
  end

  // Read FSM: memory is read one cycle ahead, only when the output slot is free or draining.
  always_comb begin
    r_state_d     = r_state_q;
    r_start_d     = r_start_q;
    r_len_d       = r_len_q;
    r_beat_d      = r_beat_q;
    rd_en         = 1'b0;
    rd_idx        = r_start_q + IdxW'(r_beat_q + 8'd1);
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        s_axi_arready = ready_en_q;
        if (s_axi_arvalid && ready_en_q) begin
          r_start_d = s_axi_araddr[OffW +: IdxW];
          r_len_d   = s_axi_arlen;
          r_beat_d  = '0;
          rd_idx    = s_axi_araddr[OffW +: IdxW];
          rd_en     = 1'b1;
          r_state_d = RData;
        end
      end
      RData: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = (r_beat_q == r_len_q);
        if (s_axi_rready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = RIdle;
          end else begin
            r_beat_d = r_beat_q + 8'd1;
            rd_en    = 1'b1;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Read data register; non-blocking read against the write port gives read-first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[rd_idx];
  end

  assign s_axi_rdata = rdata_q;

`ifdef AXIM_MEM_SLAVE_PROTO_CHK_EN
  logic proto_err_q;

  // Sticky flag: wlast must be high exactly on beat awlen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      proto_err_q <= 1'b0;
    end else if (w_state_q == WData && s_axi_wvalid &&
                 (s_axi_wlast != (w_beat_q == w_len_q))) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_axim_mem_slave.sv
// Directed bench for axim_mem_slave with a read-data scoreboard and a reference memory model.
module tb_axim_mem_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [31:0] s_axi_rdata;
  logic        s_axi_rlast;
`ifdef AXIM_MEM_SLAVE_PROTO_CHK_EN
  logic        proto_err;
`endif

  axim_mem_slave dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rlast   (s_axi_rlast)
`ifdef AXIM_MEM_SLAVE_PROTO_CHK_EN
    ,
    .proto_err     (proto_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [1024];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  int          total = 0;
  int          bad = 0;
  exp_t        e;

  // Advance to just after the next rising edge: inputs change and outputs are sampled here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr, input int beat);
    return (int'(addr[11:2]) + beat) % 1024;
  endfunction

  // Write burst from wdat/wstb; wlast is driven high on beat wl_beat; bready held low bwait cycles.
  task automatic wr_burst(input logic [31:0] addr, input int len, input int wl_beat,
                          input int bwait);
    int idx;
    s_axi_awaddr  = addr;
    s_axi_awlen   = 8'(len);
    s_axi_awvalid = 1'b1;
    for (int n = 0; n < 20 && !s_axi_awready; n++) cyc();
    chk("awready", s_axi_awready, 1);
    cyc();
    s_axi_awvalid = 1'b0;
    chk("awready_drop", s_axi_awready, 0);
    for (int i = 0; i <= len; i++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wdat[i];
      s_axi_wstrb  = wstb[i];
      s_axi_wlast  = (i == wl_beat);
      chk("wready", s_axi_wready, 1);
      chk("bvalid_early", s_axi_bvalid, 0);
      idx = widx(addr, i);
      for (int b = 0; b < 4; b++) if (wstb[i][b]) model[idx][8*b +: 8] = wdat[i][8*b +: 8];
      cyc();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    chk("bvalid", s_axi_bvalid, 1);
    chk("wready_drop", s_axi_wready, 0);
    for (int k = 0; k < bwait; k++) begin
      cyc();
      chk("bvalid_hold", s_axi_bvalid, 1);
    end
    s_axi_bready = 1'b1;
    cyc();
    s_axi_bready = 1'b0;
    chk("bvalid_once", s_axi_bvalid, 0);
  endtask

  // Read burst; mode 0 holds rready high, mode 1 drives 1,0,0 repeating. abort >= 0 stops early.
  task automatic rd_burst(input logic [31:0] addr, input int len, input int mode, input int abort);
    int          got = 0;
    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    for (int i = 0; i <= len; i++) sb.push_back('{d: model[widx(addr, i)], l: (i == len)});
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    s_axi_arvalid = 1'b1;
    for (int n = 0; n < 20 && !s_axi_arready; n++) cyc();
    chk("arready", s_axi_arready, 1);
    cyc();
    s_axi_arvalid = 1'b0;
    chk("arready_drop", s_axi_arready, 0);
    for (int c = 0; c < 200 && got <= len; c++) begin
      if (abort >= 0 && got == abort) break;
      s_axi_rready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      if (c == 0) chk("rvalid_first", s_axi_rvalid, 1);
      if (stalled) chk("rdata_stable", s_axi_rdata, held);
      if (s_axi_rvalid && s_axi_rready) begin
        e = sb.pop_front();
        chk("rdata", s_axi_rdata, e.d);
        chk("rlast", s_axi_rlast, e.l);
        got++;
        stalled = 1'b0;
      end else begin
        chk("rvalid_stall", s_axi_rvalid, 1);
        chk("rlast_stall", s_axi_rlast, (got == len));
        held    = s_axi_rdata;
        stalled = 1'b1;
      end
      cyc();
    end
    s_axi_rready = 1'b0;
    if (abort < 0) begin
      chk("rd_beats", got, len + 1);
      chk("rvalid_end", s_axi_rvalid, 0);
      chk("sb_empty", sb.size(), 0);
    end
  endtask

  // Hard stop in case the directed sequence wedges.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    cyc();
    cyc();
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    rstn = 1'b1;
    cyc();
    chk("post_rst_awready", s_axi_awready, 1);
    chk("post_rst_arready", s_axi_arready, 1);
`ifdef AXIM_MEM_SLAVE_PROTO_CHK_EN
    chk("proto_err_rst", proto_err, 0);
`endif

    // Write then read back
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'hA0 + i;
      wstb[i] = 4'hF;
    end
    wr_burst(32'h40, 3, 3, 0);
    rd_burst(32'h40, 3, 0, -1);

    // Byte strobes
    wdat[0] = 32'hFFFF_FFFF;
    wstb[0] = 4'hF;
    wr_burst(32'h80, 0, 0, 0);
    wdat[0] = 32'h1234_5678;
    wstb[0] = 4'b0101;
    wr_burst(32'h80, 0, 0, 0);
    chk("strobe_model", model[32], 32'hFF34_FF78);
    rd_burst(32'h80, 0, 0, -1);

    // Wrap past the top of memory
    wdat[0] = 32'h1111_0001;
    wdat[1] = 32'h2222_0002;
    wstb[0] = 4'hF;
    wstb[1] = 4'hF;
    wr_burst(32'hFFC, 1, 1, 0);
    rd_burst(32'h0, 0, 0, -1);
    rd_burst(32'hFFC, 1, 0, -1);

    // Backpressure on both B and R
    for (int i = 0; i < 8; i++) begin
      wdat[i] = 32'hB0 + i;
      wstb[i] = 4'hF;
    end
    wr_burst(32'h100, 7, 7, 5);
    rd_burst(32'h100, 7, 1, -1);

    // Concurrent AW and AR to the same word in the same cycle
    wdat[0] = 32'h5555_0000;
    wstb[0] = 4'hF;
    wr_burst(32'h200, 0, 0, 0);
    sb.push_back('{d: model[128], l: 1'b1});
    s_axi_awaddr  = 32'h200;
    s_axi_awlen   = 8'd0;
    s_axi_awvalid = 1'b1;
    s_axi_araddr  = 32'h200;
    s_axi_arlen   = 8'd0;
    s_axi_arvalid = 1'b1;
    chk("cc_awready", s_axi_awready, 1);
    chk("cc_arready", s_axi_arready, 1);
    cyc();
    s_axi_awvalid = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_wvalid  = 1'b1;
    s_axi_wdata   = 32'hAAAA_1111;
    s_axi_wstrb   = 4'hF;
    s_axi_wlast   = 1'b1;
    s_axi_rready  = 1'b1;
    chk("cc_wready", s_axi_wready, 1);
    chk("cc_rvalid", s_axi_rvalid, 1);
    e = sb.pop_front();
    chk("cc_rdata_old", s_axi_rdata, e.d);
    chk("cc_rlast", s_axi_rlast, e.l);
    model[128] = 32'hAAAA_1111;
    cyc();
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    s_axi_rready = 1'b0;
    chk("cc_rvalid_end", s_axi_rvalid, 0);
    chk("cc_bvalid", s_axi_bvalid, 1);
    s_axi_bready = 1'b1;
    cyc();
    s_axi_bready = 1'b0;

    // W beat write and AR read of the same word on the same edge: read-first
    s_axi_awaddr  = 32'h200;
    s_axi_awvalid = 1'b1;
    cyc();
    s_axi_awvalid = 1'b0;
    sb.push_back('{d: model[128], l: 1'b1});
    s_axi_wvalid  = 1'b1;
    s_axi_wdata   = 32'h0BAD_F00D;
    s_axi_wlast   = 1'b1;
    s_axi_araddr  = 32'h200;
    s_axi_arvalid = 1'b1;
    chk("rf_wready", s_axi_wready, 1);
    chk("rf_arready", s_axi_arready, 1);
    model[128] = 32'h0BAD_F00D;
    cyc();
    s_axi_wvalid  = 1'b0;
    s_axi_wlast   = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    s_axi_bready  = 1'b1;
    e = sb.pop_front();
    chk("rf_rvalid", s_axi_rvalid, 1);
    chk("rf_rdata_old", s_axi_rdata, e.d);
    chk("rf_bvalid", s_axi_bvalid, 1);
    cyc();
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    chk("rf_rvalid_end", s_axi_rvalid, 0);
    chk("rf_bvalid_end", s_axi_bvalid, 0);
    rd_burst(32'h200, 0, 0, -1);

    // Reset in the middle of a read burst
    rd_burst(32'h100, 7, 0, 2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rvalid", s_axi_rvalid, 0);
    chk("mid_rst_rlast", s_axi_rlast, 0);
    chk("mid_rst_rdata", s_axi_rdata, 0);
    chk("mid_rst_arready", s_axi_arready, 0);
    sb.delete();
    cyc();
    cyc();
    rstn = 1'b1;
    cyc();
    chk("mid_rst_arready_back", s_axi_arready, 1);
    rd_burst(32'h104, 1, 0, -1);

`ifdef AXIM_MEM_SLAVE_PROTO_CHK_EN
    // wlast on beat 1 of a len 3 burst: flag sets, burst still runs 4 beats
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'hC0 + i;
      wstb[i] = 4'hF;
    end
    chk("proto_err_clean", proto_err, 0);
    wr_burst(32'h300, 3, 1, 0);
    chk("proto_err_set", proto_err, 1);
    rd_burst(32'h300, 3, 0, -1);
    wr_burst(32'h310, 0, 0, 0);
    chk("proto_err_sticky", proto_err, 1);
    rstn = 1'b0;
    #1;
    chk("proto_err_cleared", proto_err, 0);
    cyc();
    rstn = 1'b1;
    cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axim_mem_slave.md
# axim_mem_slave

AXI4 memory-mapped responder backed by an internal word-addressed memory array, answering the burst traffic produced by the vector unit's AXI master controller. It provides the far end of that controller's read and write channels so the load/store path can be exercised and run standalone without an external interconnect or DDR model. Read and write channels are fully independent, and each channel handles one burst at a time.

## Interface
- C_S_AXI_ADDR_WIDTH, 32: byte address width.
- C_S_AXI_DATA_WIDTH, 32: data width in bits; power of 2, at least 32.
- C_MEM_DEPTH, 1024: memory depth in data words; power of 2.
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- s_axi_awvalid/awready  in/out  1  write-address handshake.
- s_axi_awaddr  in  ADDR  burst start byte address.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_wvalid/wready  in/out  1  write-data handshake.
- s_axi_wdata  in  DATA  write beat.
- s_axi_wstrb  in  DATA/8  byte enables.
- s_axi_wlast  in  1  last write beat marker.
- s_axi_bvalid/bready  out/in  1  write response; always OKAY, no bresp port.
- s_axi_arvalid/arready  in/out  1  read-address handshake.
- s_axi_araddr  in  ADDR  burst start byte address.
- s_axi_arlen  in  8  beats minus 1.
- s_axi_rvalid/rready  out/in  1  read-data handshake.
- s_axi_rdata  out  DATA  read beat.
- s_axi_rlast  out  1  asserted on the final read beat.
- proto_err  out  1  sticky protocol error flag; present only with the configuration macro.

## Operation
- Word index = addr[LOG2(DATA/8) +: LOG2(C_MEM_DEPTH)]. Low byte-offset bits are ignored. Higher bits are ignored, so memory aliases.
- Bursts are INCR only. Beat n of a burst targets the start word index + n, modulo C_MEM_DEPTH; a burst that runs past the top wraps to index 0.
- Write FSM:
  - W_IDLE: awready=1. An AW handshake latches the start index and awlen and clears the beat counter, then goes to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb and increments the beat counter. The handshake on beat == awlen goes to W_RESP.
  - W_RESP: bvalid=1, held until bready. The B handshake returns to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. An AR handshake latches the start index and arlen, then goes to R_DATA.
  - R_DATA: rvalid=1, and rlast=1 when beat == arlen. Each R handshake advances the beat. The rlast handshake returns to R_IDLE.
- The burst length is set by the beat counter alone; wlast never terminates a burst.
- rdata, rvalid and rlast hold stable while rvalid=1 and rready=0.
- Simultaneous read and write of the same word in the same cycle: the read returns the old data (read-first).
- Reset: both FSMs go to idle and the counters clear. Reset-time output values:
  - awready=1 and arready=1 from the first clock after rstn deasserts; both 0 while rstn is asserted.
  - wready, bvalid, rvalid, rlast, rdata all 0.
  - Memory contents are not reset.
  - A reset mid-burst abandons the burst; no B or R response is issued for it.

## Timing
- AW or AR is accepted in the cycle it is presented while idle; the ready signal deasserts the next cycle.
- wready asserts in the cycle after the AW handshake. Write beats are accepted back-to-back, one per cycle.
- bvalid asserts in the cycle after the last W handshake.
- First rvalid asserts in the cycle after the AR handshake (one cycle of synchronous memory latency). Beats follow back-to-back while rready=1.
- rready low inserts stalls with no beat loss or duplication; the memory read is enabled only when (!rvalid || rready).
- Earliest next AW is 1 cycle after the B handshake. Earliest next AR is 1 cycle after the rlast handshake.
- Read and write bursts overlap freely with no cross-channel stalls.

## Configuration
- AXIM_MEM_SLAVE_PROTO_CHK_EN defined:
  - proto_err sets when wlast=1 on a beat other than beat awlen, or wlast=0 on beat awlen.
  - It is sticky until rstn; burst behaviour is unchanged.
- Macro undefined: the proto_err port and its checker are not compiled in, and wlast is ignored.

## Test plan
- Write then read back:
  - Stimulus: AW addr 0x40, len 3, data 0xA0..0xA3, wstrb all ones; then AR addr 0x40, len 3.
  - Response: rdata 0xA0,0xA1,0xA2,0xA3; rlast only on beat 3; bvalid exactly once.
- Byte strobes: write 0xFFFFFFFF, then write 0x12345678 with wstrb 0b0101 to the same word; read back returns 0xFF34FF78.
- Wrap: with C_MEM_DEPTH=1024 and 32-bit data, burst at addr 0xFFC len 1 writes words 1023 and 0; reading addr 0x0 returns the second beat.
- Backpressure:
  - Stimulus: AR len 7 with rready toggling 1,0,0,1,... and bready held 0 for 5 cycles.
  - Response: 8 distinct in-order beats with rdata stable across stalls; bvalid held until bready.
- Concurrency and reset:
  - Concurrent AW and AR to the same word in the same cycle: the read returns the pre-write value.
  - Reset: assert rstn low mid-read burst; rvalid=0 immediately, then a new AR after release returns correct data.
- With AXIM_MEM_SLAVE_PROTO_CHK_EN: len 3 burst with wlast on beat 1 sets proto_err=1, burst completes after 4 beats, and proto_err holds until reset.
